// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the multi-channel UART <-> RAM bridge:
// register offsets, arbiter states and FIFO entry sizing helpers.
package uart_bridge_pkg;

    // Register offsets inside the 64-byte bridge window
    localparam logic [5:0] TX_OFS   = 6'h00;
    localparam logic [5:0] WPTR_OFS = 6'h20;
    localparam logic [5:0] MASK_OFS = 6'h3C;

    // Owner of the RAM/CPU handshake in any given cycle
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_MEM,
        ST_DMA_WR,
        ST_MMIO_ACK
    } arb_state_t;

    // Channel field width of a FIFO entry; never narrower than one bit
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // FIFO entry is {channel, byte}
    function automatic int entry_width(input int nch);
        return ch_width(nch) + 8;
    endfunction

endpackage

// File: rtl/uart_bridge_fifo.sv
// Synchronous FIFO holding received {channel, byte} entries until the
// arbiter can write them to RAM. Head entry is presented on dout.
module uart_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop && !empty)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ram_bridge.sv
// UART <-> RAM bridge between the CPU wishbone port and RAM.
// CPU writes to TX registers launch bytes; received bytes are queued and
// written into per-channel RAM rings while the CPU is stalled, not clobbered.
// Optional feature: define UART_BRIDGE_IRQ_EN for o_irq and the mask register.
module uart_ram_bridge
    import uart_bridge_pkg::*;
#(
    parameter int          NCH        = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter int          RING_WORDS = 64,
    parameter logic [31:0] RX_BASE    = 32'h0000_0730,
    parameter logic [31:0] MMIO_BASE  = 32'h00A0_0000
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst_n,
    input  logic [31:0]      i_cpu_adr,
    input  logic [31:0]      i_cpu_dat,
    input  logic [3:0]       i_cpu_sel,
    input  logic             i_cpu_we,
    input  logic             i_cpu_cyc,
    output logic [31:0]      o_cpu_rdt,
    output logic             o_cpu_ack,
    output logic [31:0]      o_ram_adr,
    output logic [31:0]      o_ram_dat,
    output logic [3:0]       o_ram_sel,
    output logic             o_ram_we,
    output logic             o_ram_cyc,
    input  logic [31:0]      i_ram_rdt,
    input  logic             i_ram_ack,
    input  logic [NCH-1:0]   i_rx_done,
    input  logic [NCH*8-1:0] i_rx_dat,
    output logic [NCH*8-1:0] o_tx_dat,
    output logic [NCH-1:0]   o_tx_start,
    input  logic [NCH-1:0]   i_tx_busy
`ifdef UART_BRIDGE_IRQ_EN
    ,
    output logic             o_irq
`endif
);
    localparam int CH_W   = ch_width(NCH);
    localparam int ENT_W  = entry_width(NCH);
    localparam int WPTR_W = $clog2(RING_WORDS);

    arb_state_t                   state;
    logic [NCH-1:0][7:0]          tx_byte;
    logic [NCH-1:0][7:0]          hold;
    logic [NCH-1:0]               pend, hvalid, ovf, newd;
    logic [NCH-1:0][WPTR_W-1:0]   wptr;
    logic [CH_W-1:0]              rr, mv_ch, dma_ch;
    logic                         mv_valid, mv_go;
    logic [7:0]                   mv_byte, dma_byte;
    logic [WPTR_W-1:0]            dma_wptr;
    logic [ENT_W-1:0]             fifo_dout;
    logic                         fifo_full, fifo_empty;
    logic                         cpu_req, win_hit, is_tx, is_wptr, is_mask;
    logic                         mmio_go, dma_go, dma_done;
    logic [2:0]                   reg_idx;
    logic [31:0]                  mmio_rdata, dma_adr;
`ifdef UART_BRIDGE_IRQ_EN
    logic [NCH-1:0]               irq_mask;

    assign o_irq = |((newd | ovf) & irq_mask);
`endif

    assign o_tx_dat = tx_byte;

    // A request already being acked must not be taken as a new one.
    // The mask offset wins over a WPTR index that would alias it (NCH=8).
    assign cpu_req  = i_cpu_cyc && !o_cpu_ack;
    assign win_hit  = (i_cpu_adr[31:6] == MMIO_BASE[31:6]);
    assign reg_idx  = i_cpu_adr[4:2];
    assign is_mask  = (i_cpu_adr[5:0] == MASK_OFS);
    assign is_tx    = (i_cpu_adr[5] == TX_OFS[5]) && (32'(reg_idx) < NCH);
    assign is_wptr  = (i_cpu_adr[5] == WPTR_OFS[5]) && (32'(reg_idx) < NCH) && !is_mask;
    assign dma_go   = (state == ST_IDLE) && !fifo_empty && (!cpu_req || fifo_full);
    assign mmio_go  = (state == ST_IDLE) && !dma_go && cpu_req && win_hit;
    assign dma_done = (state == ST_DMA_WR) && i_ram_ack;
    assign dma_ch   = fifo_dout[ENT_W-1:8];
    assign dma_byte = fifo_dout[7:0];
    assign dma_adr  = RX_BASE + 32'({dma_ch, dma_wptr, 2'b00});
    assign mv_go    = mv_valid && !fifo_full;

    uart_bridge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (i_wb_clk),
        .rst_n (i_wb_rst_n),
        .push  (mv_go),
        .din   ({mv_ch, mv_byte}),
        .pop   (dma_done),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Round-robin pick of the next valid hold, plus register read mux
    always_comb begin
        int idx;
        idx        = 0;
        mv_valid   = 1'b0;
        mv_ch      = '0;
        mv_byte    = '0;
        dma_wptr   = '0;
        mmio_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr) + k) % NCH;
            if (!mv_valid && hvalid[idx]) begin
                mv_valid = 1'b1;
                mv_ch    = CH_W'(idx);
                mv_byte  = hold[idx];
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (dma_ch == CH_W'(c))
                dma_wptr = wptr[c];
            if (is_tx && reg_idx == 3'(c))
                mmio_rdata = {30'b0, pend[c], i_tx_busy[c]};
            if (is_wptr && reg_idx == 3'(c))
                mmio_rdata = {ovf[c], newd[c], {(30-WPTR_W){1'b0}}, wptr[c]};
        end
`ifdef UART_BRIDGE_IRQ_EN
        if (is_mask)
            mmio_rdata = 32'(irq_mask);
`endif
    end

    // TX launch: a write defers the start by a cycle so the byte is stable
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            tx_byte    <= '0;
            pend       <= '0;
            o_tx_start <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (mmio_go && i_cpu_we && is_tx && reg_idx == 3'(c)) begin
                    tx_byte[c]    <= i_cpu_dat[7:0];
                    pend[c]       <= 1'b1;
                    o_tx_start[c] <= 1'b0;
                end else if (pend[c] && !i_tx_busy[c]) begin
                    o_tx_start[c] <= 1'b1;
                    pend[c]       <= 1'b0;
                end else begin
                    o_tx_start[c] <= 1'b0;
                end
            end
        end
    end

    // RX capture: a hold being drained this cycle can accept a new byte;
    // a fresh overflow wins over a same-cycle clear from a WPTR write
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            hold   <= '0;
            hvalid <= '0;
            ovf    <= '0;
            rr     <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (mmio_go && i_cpu_we && is_wptr && reg_idx == 3'(c))
                    ovf[c] <= 1'b0;
                if (i_rx_done[c]) begin
                    if (!hvalid[c] || (mv_go && mv_ch == CH_W'(c))) begin
                        hold[c]   <= i_rx_dat[8*c +: 8];
                        hvalid[c] <= 1'b1;
                    end else begin
                        ovf[c] <= 1'b1;
                    end
                end else if (mv_go && mv_ch == CH_W'(c)) begin
                    hvalid[c] <= 1'b0;
                end
            end
            if (mv_go)
                rr <= (32'(mv_ch) == NCH - 1) ? '0 : mv_ch + CH_W'(1);
        end
    end

    // Arbiter: one RAM owner per cycle, registered bus and CPU outputs
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state     <= ST_IDLE;
            o_cpu_ack <= 1'b0;
            o_cpu_rdt <= '0;
            o_ram_adr <= '0;
            o_ram_dat <= '0;
            o_ram_sel <= '0;
            o_ram_we  <= 1'b0;
            o_ram_cyc <= 1'b0;
            wptr      <= '0;
            newd      <= '0;
`ifdef UART_BRIDGE_IRQ_EN
            irq_mask  <= '0;
`endif
        end else begin
            o_cpu_ack <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (mmio_go && !i_cpu_we && is_wptr && reg_idx == 3'(c))
                    newd[c] <= 1'b0;
            end
`ifdef UART_BRIDGE_IRQ_EN
            if (mmio_go && i_cpu_we && is_mask)
                irq_mask <= i_cpu_dat[NCH-1:0];
`endif
            case (state)
                ST_IDLE: begin
                    if (dma_go) begin
                        state     <= ST_DMA_WR;
                        o_ram_adr <= dma_adr;
                        o_ram_dat <= {24'b0, dma_byte};
                        o_ram_sel <= 4'hF;
                        o_ram_we  <= 1'b1;
                        o_ram_cyc <= 1'b1;
                    end else if (mmio_go) begin
                        state     <= ST_MMIO_ACK;
                        o_cpu_ack <= 1'b1;
                        o_cpu_rdt <= mmio_rdata;
                    end else if (cpu_req) begin
                        state     <= ST_CPU_MEM;
                        o_ram_adr <= i_cpu_adr;
                        o_ram_dat <= i_cpu_dat;
                        o_ram_sel <= i_cpu_sel;
                        o_ram_we  <= i_cpu_we;
                        o_ram_cyc <= 1'b1;
                    end
                end
                ST_CPU_MEM: begin
                    if (i_ram_ack) begin
                        state     <= ST_IDLE;
                        o_cpu_rdt <= i_ram_rdt;
                        o_cpu_ack <= 1'b1;
                        o_ram_adr <= '0;
                        o_ram_dat <= '0;
                        o_ram_sel <= '0;
                        o_ram_we  <= 1'b0;
                        o_ram_cyc <= 1'b0;
                    end
                end
                ST_DMA_WR: begin
                    if (i_ram_ack) begin
                        state     <= ST_IDLE;
                        o_ram_adr <= '0;
                        o_ram_dat <= '0;
                        o_ram_sel <= '0;
                        o_ram_we  <= 1'b0;
                        o_ram_cyc <= 1'b0;
                        for (int c = 0; c < NCH; c++) begin
                            if (dma_ch == CH_W'(c)) begin
                                wptr[c] <= wptr[c] + WPTR_W'(1);
                                newd[c] <= 1'b1;
                            end
                        end
                    end
                end
                ST_MMIO_ACK: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Directed bench for uart_ram_bridge: TX launch, RX-to-RAM rings, ring wrap,
// FIFO overflow under a stalled RAM, and reset during a DMA write.
// Honours UART_BRIDGE_IRQ_EN when defined for the mask register read-back.
module tb_uart_ram_bridge;

    localparam logic [31:0] MMIO = 32'h00A0_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_adr, cpu_dat;
    logic [3:0]  cpu_sel;
    logic        cpu_we, cpu_cyc;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic [31:0] ram_adr, ram_dat;
    logic [3:0]  ram_sel;
    logic        ram_we, ram_cyc;
    logic [31:0] ram_rdt;
    logic        ram_ack;
    logic [1:0]  rx_done;
    logic [15:0] rx_dat;
    logic [15:0] tx_dat;
    logic [1:0]  tx_start;
    logic [1:0]  tx_busy;
`ifdef UART_BRIDGE_IRQ_EN
    logic        irq;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          ram_wr_cnt = 0;
    logic [31:0] last_wr_adr = '0;
    logic [31:0] last_wr_dat = '0;
    logic        ram_stall = 1'b0;
    logic [31:0] mem [0:1023];
    int          start_cnt0 = 0;
    int          start_cnt1 = 0;
    logic [7:0]  last_tx0 = '0;
    logic [7:0]  last_tx1 = '0;

    uart_ram_bridge dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_cpu_adr  (cpu_adr),
        .i_cpu_dat  (cpu_dat),
        .i_cpu_sel  (cpu_sel),
        .i_cpu_we   (cpu_we),
        .i_cpu_cyc  (cpu_cyc),
        .o_cpu_rdt  (cpu_rdt),
        .o_cpu_ack  (cpu_ack),
        .o_ram_adr  (ram_adr),
        .o_ram_dat  (ram_dat),
        .o_ram_sel  (ram_sel),
        .o_ram_we   (ram_we),
        .o_ram_cyc  (ram_cyc),
        .i_ram_rdt  (ram_rdt),
        .i_ram_ack  (ram_ack),
        .i_rx_done  (rx_done),
        .i_rx_dat   (rx_dat),
        .o_tx_dat   (tx_dat),
        .o_tx_start (tx_start),
        .i_tx_busy  (tx_busy)
`ifdef UART_BRIDGE_IRQ_EN
        ,
        .o_irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    // RAM responder: one-cycle ack pulse unless stalled, logs every write
    always @(negedge clk) begin
        if (ram_cyc && !ram_ack && !ram_stall) begin
            ram_ack = 1'b1;
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b])
                        mem[ram_adr[11:2]][8*b +: 8] = ram_dat[8*b +: 8];
                ram_wr_cnt  = ram_wr_cnt + 1;
                last_wr_adr = ram_adr;
                last_wr_dat = ram_dat;
            end
            ram_rdt = mem[ram_adr[11:2]];
        end else begin
            ram_ack = 1'b0;
        end
    end

    // Transmit-start monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_start[0]) begin
            start_cnt0 = start_cnt0 + 1;
            last_tx0   = tx_dat[7:0];
        end
        if (tx_start[1]) begin
            start_cnt1 = start_cnt1 + 1;
            last_tx1   = tx_dat[15:8];
        end
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ram_word(input logic [31:0] adr);
        return mem[adr[11:2]];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              output logic [31:0] rdata, output logic ok);
        @(negedge clk);
        cpu_cyc = 1'b1;
        cpu_we  = we;
        cpu_adr = adr;
        cpu_dat = dat;
        cpu_sel = 4'hF;
        ok      = 1'b0;
        rdata   = '0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ack) begin
                ok    = 1'b1;
                rdata = cpu_rdt;
                break;
            end
        end
        @(negedge clk);
        cpu_cyc = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic cpuWrite(input logic [31:0] adr, input logic [31:0] dat, input string tag);
        logic [31:0] r;
        logic        ok;
        cpu_access(1'b1, adr, dat, r, ok);
        checkOutput({tag, " ack"}, 32'(ok), 32'd1);
    endtask

    task automatic cpuRead(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        logic        ok;
        cpu_access(1'b0, adr, 32'h0, r, ok);
        checkOutput({tag, " ack"}, 32'(ok), 32'd1);
        checkOutput(tag, r, exp);
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] b);
        @(negedge clk);
        rx_done[ch]        = 1'b1;
        rx_dat[8*ch +: 8]  = b;
        @(negedge clk);
        rx_done            = '0;
    endtask

    task automatic waitRamWrites(input int target, input string tag);
        for (int i = 0; i < 500; i++) begin
            if (ram_wr_cnt >= target) break;
            @(posedge clk);
            #1;
        end
        checkOutput(tag, 32'(ram_wr_cnt), 32'(target));
    endtask

    initial begin
        int          base;
        int          acks;
        logic        got;
        logic [31:0] held_rdt;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        cpu_adr = '0;
        cpu_dat = '0;
        cpu_sel = '0;
        cpu_we  = 1'b0;
        cpu_cyc = 1'b0;
        ram_rdt = '0;
        ram_ack = 1'b0;
        rx_done = '0;
        rx_dat  = '0;
        tx_busy = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset cpu_ack", 32'(cpu_ack), 32'd0);
        checkOutput("reset ram_cyc", 32'(ram_cyc), 32'd0);
        checkOutput("reset tx_start", 32'(tx_start), 32'd0);
        checkOutput("reset tx_dat", 32'(tx_dat), 32'd0);

        $display("[TB] TX on idle channel 0");
        base = start_cnt0;
        cpuWrite(MMIO + 32'h00, 32'h41, "tx0 write");
        repeat (4) @(negedge clk);
        checkOutput("tx0 start count", 32'(start_cnt0 - base), 32'd1);
        checkOutput("tx0 byte", 32'(last_tx0), 32'h41);
        cpuRead(MMIO + 32'h00, 32'h0, "tx0 status");

        $display("[TB] TX on busy channel 1");
        tx_busy = 2'b10;
        base = start_cnt1;
        cpuWrite(MMIO + 32'h04, 32'h55, "tx1 write a");
        cpuWrite(MMIO + 32'h04, 32'h66, "tx1 write b");
        repeat (4) @(negedge clk);
        checkOutput("tx1 held while busy", 32'(start_cnt1 - base), 32'd0);
        cpuRead(MMIO + 32'h04, 32'h3, "tx1 pend+busy");
        tx_busy = 2'b00;
        repeat (4) @(negedge clk);
        checkOutput("tx1 start count", 32'(start_cnt1 - base), 32'd1);
        checkOutput("tx1 last byte", 32'(last_tx1), 32'h66);
        cpuRead(MMIO + 32'h04, 32'h0, "tx1 status idle");

        $display("[TB] unmapped and mask offsets");
        cpuRead(MMIO + 32'h10, 32'h0, "unmapped read");
        cpuWrite(MMIO + 32'h3C, 32'hFF, "mask write");
`ifdef UART_BRIDGE_IRQ_EN
        cpuRead(MMIO + 32'h3C, 32'h3, "mask read");
`else
        cpuRead(MMIO + 32'h3C, 32'h0, "mask read");
`endif

        $display("[TB] CPU RAM pass-through");
        base = ram_wr_cnt;
        cpuWrite(32'h0000_0100, 32'hDEAD_BEEF, "cpu ram write");
        checkOutput("cpu ram write count", 32'(ram_wr_cnt - base), 32'd1);
        cpuRead(32'h0000_0100, 32'hDEAD_BEEF, "cpu ram read");

        $display("[TB] RX byte to RAM ring 0");
        base = ram_wr_cnt;
        applyStimulus(0, 8'h5A);
        waitRamWrites(base + 1, "rx0 dma count");
        checkOutput("rx0 dma addr", last_wr_adr, 32'h0000_0730);
        checkOutput("rx0 dma data", last_wr_dat, 32'h0000_005A);
        cpuRead(MMIO + 32'h20, 32'h4000_0001, "wptr0 newd");
        cpuRead(MMIO + 32'h20, 32'h0000_0001, "wptr0 newd cleared");

        $display("[TB] ring wrap on channel 1");
        for (int k = 0; k < 65; k++) begin
            base = ram_wr_cnt;
            applyStimulus(1, 8'(k + 1));
            waitRamWrites(base + 1, "ring write");
        end
        checkOutput("wrap last addr", last_wr_adr, 32'h0000_0830);
        checkOutput("wrap slot0", ram_word(32'h0000_0830), 32'h0000_0041);
        checkOutput("wrap slot1", ram_word(32'h0000_0834), 32'h0000_0002);
        checkOutput("wrap slot63", ram_word(32'h0000_092C), 32'h0000_0040);
        cpuRead(MMIO + 32'h24, 32'h4000_0001, "wptr1 after wrap");
        cpuRead(MMIO + 32'h20, 32'h0000_0001, "wptr0 untouched");

        $display("[TB] overflow and contention with stalled RAM");
        ram_stall = 1'b1;
        base = ram_wr_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rx_done[0]  = 1'b1;
            rx_dat[7:0] = 8'(8'h80 + k);
        end
        @(negedge clk);
        rx_done = '0;
        repeat (5) @(negedge clk);
        checkOutput("stall dma cyc", 32'(ram_cyc), 32'd1);
        checkOutput("stall dma addr", ram_adr, 32'h0000_0734);
        checkOutput("stall dma data", ram_dat, 32'h0000_0080);
        cpu_cyc = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = MMIO + 32'h20;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ack) acks++;
        end
        checkOutput("cpu held during dma", 32'(acks), 32'd0);
        @(negedge clk);
        ram_stall = 1'b0;
        got = 1'b0;
        held_rdt = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ack) begin
                got = 1'b1;
                held_rdt = cpu_rdt;
                break;
            end
        end
        @(negedge clk);
        cpu_cyc = 1'b0;
        checkOutput("held read ack", 32'(got), 32'd1);
        checkOutput("held read wptr0", held_rdt, 32'hC000_0002);
        waitRamWrites(base + 9, "overflow drain count");
        repeat (10) @(negedge clk);
        checkOutput("dropped byte not written", 32'(ram_wr_cnt - base), 32'd9);
        checkOutput("first stalled byte", ram_word(32'h0000_0734), 32'h0000_0080);
        checkOutput("last kept byte", ram_word(32'h0000_0754), 32'h0000_0088);
        cpuRead(MMIO + 32'h20, 32'hC000_000A, "wptr0 ovf");
        cpuWrite(MMIO + 32'h20, 32'h0, "wptr0 clear ovf");
        cpuRead(MMIO + 32'h20, 32'h0000_000A, "wptr0 cleared");

        $display("[TB] reset during DMA write");
        ram_stall = 1'b1;
        applyStimulus(1, 8'h77);
        for (int i = 0; i < 20; i++) begin
            if (ram_cyc) break;
            @(posedge clk);
            #1;
        end
        checkOutput("dma started", 32'(ram_cyc), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst ram_cyc", 32'(ram_cyc), 32'd0);
        checkOutput("rst ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst ram_adr", ram_adr, 32'h0);
        checkOutput("rst ram_dat", ram_dat, 32'h0);
        checkOutput("rst cpu_ack", 32'(cpu_ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ram_stall = 1'b0;
        base = ram_wr_cnt;
        repeat (10) @(negedge clk);
        checkOutput("fifo empty after reset", 32'(ram_wr_cnt - base), 32'd0);
        cpuRead(MMIO + 32'h20, 32'h0, "wptr0 after reset");
        cpuRead(MMIO + 32'h24, 32'h0, "wptr1 after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
